// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO; frames are LSB first with optional parity and 1-2 stop bits.
// Latency: a write into an idle, empty block drives the start bit one cycle later.
// Backpressure: none on the write side; a write while full is dropped and flagged by overflow.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [DATA_BITS-1:0]              wr_data,
    input  logic                              wr_en,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              overflow,
    output logic                              busy,
    output logic                              txd
);

    localparam int DIV   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [CW-1:0]    CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: clock divider must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 push;
    logic                 pop;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic                 par_bit;
    logic                 baud_end;
    logic                 stop_last;
    logic                 frame_done;

    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);
    assign busy       = (state != ST_IDLE);
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign stop_last  = (STOP_BITS == 1) || stop_idx;
    assign frame_done = (state == ST_STOP) && baud_end && stop_last;

    // Full is judged on the pre-edge count, so a pop in the same cycle never rescues a write.
    assign push = wr_en && !full;
    assign pop  = !empty && ((state == ST_IDLE) || frame_done);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            // A pop only happens from IDLE or at the very end of STOP; both branches below enter START.
            if (pop) begin
                shreg   <= mem[rd_ptr];
                par_bit <= (^mem[rd_ptr]) ^ (PARITY == 1);
            end
            if (state == ST_IDLE) begin
                baud_cnt <= '0;
                if (pop) begin
                    txd   <= 1'b0;
                    state <= ST_START;
                end else begin
                    txd <= 1'b1;
                end
            end else begin
                baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
                if (baud_end) begin
                    case (state)
                        ST_START: begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end
                        ST_DATA: begin
                            if (bit_idx == BIT_LAST) begin
                                if (PARITY != 0) begin
                                    txd   <= par_bit;
                                    state <= ST_PARITY;
                                end else begin
                                    txd      <= 1'b1;
                                    stop_idx <= 1'b0;
                                    state    <= ST_STOP;
                                end
                            end else begin
                                txd     <= shreg[0];
                                shreg   <= shreg >> 1;
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                        ST_PARITY: begin
                            txd      <= 1'b1;
                            stop_idx <= 1'b0;
                            state    <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (!stop_last) begin
                                stop_idx <= 1'b1;
                            end else if (pop) begin
                                txd   <= 1'b0;
                                state <= ST_START;
                            end else begin
                                txd   <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                        default: begin
                            txd   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances covering no parity, even, odd and two stop bits.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [3:0] wr_en = 4'b0000;
    logic [3:0] full;
    logic [3:0] empty;
    logic [2:0] count [4];
    logic [3:0] overflow;
    logic [3:0] busy;
    logic [3:0] txd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int P = (g == 1) ? 2 : (g == 2) ? 1 : (g == 3) ? 2 : 0;
        localparam int S = (g == 3) ? 2 : 1;
        uart_tx_fifo #(
            .CLK_HZ(12000000), .BAUD(1000000), .DATA_BITS(8),
            .PARITY(P), .STOP_BITS(S), .FIFO_DEPTH(4)
        ) u_dut (
            .clk(clk), .resetn(resetn), .wr_data(wr_data), .wr_en(wr_en[g]),
            .full(full[g]), .empty(empty[g]), .count(count[g]),
            .overflow(overflow[g]), .busy(busy[g]), .txd(txd[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write one byte into an idle instance, then sample every bit at mid-bit and time the frame.
    task automatic send_capture(input int g, input logic [7:0] d, input logic [15:0] exp_bits,
                                input int exp_len, input string tag);
        logic [15:0] bits;
        int          len;
        wr_data  = d;
        wr_en[g] = 1'b1;
        tick();
        wr_en[g] = 1'b0;
        check({tag, "_count_after_write"}, 32'(count[g]), 32'd1);
        check({tag, "_txd_at_write_edge"}, 32'(txd[g]), 32'd1);
        tick();
        check({tag, "_txd_falls"}, 32'(txd[g]), 32'd0);
        check({tag, "_busy_rises"}, 32'(busy[g]), 32'd1);
        check({tag, "_count_after_pop"}, 32'(count[g]), 32'd0);
        bits = '0;
        len  = 0;
        for (int c = 0; c < 400; c++) begin
            if (!busy[g]) break;
            if (c % 12 == 6 && c / 12 < 16) bits[c / 12] = txd[g];
            tick();
            len++;
        end
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        check({tag, "_frame_len"}, 32'(len), 32'(exp_len));
        check({tag, "_txd_idle_after"}, 32'(txd[g]), 32'd1);
    endtask

    logic [7:0]  seq [5];
    logic [49:0] cap;
    logic        seen;

    initial begin
        seq = '{8'h3C, 8'hA1, 8'h0F, 8'hF0, 8'h96};

        // Reset state
        #22;
        check("rst_txd", 32'(txd[0]), 32'd1);
        check("rst_empty", 32'(empty[0]), 32'd1);
        check("rst_full", 32'(full[0]), 32'd0);
        check("rst_count", 32'(count[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_overflow", 32'(overflow[0]), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Basic frames: 8N1, even, odd, even with two stop bits
        send_capture(0, 8'h55, 16'h02AA, 120, "f55_8n1");
        send_capture(1, 8'h07, 16'h060E, 132, "f07_even");
        send_capture(2, 8'h07, 16'h040E, 132, "f07_odd");
        send_capture(3, 8'h07, 16'h0E0E, 144, "f07_even_2stop");

        // Five consecutive writes, then one more at full; all accepted bytes go out back to back
        wr_en[0] = 1'b1;
        wr_data = seq[0]; tick();
        check("burst_count_e1", 32'(count[0]), 32'd1);
        wr_data = seq[1]; tick();
        check("burst_count_e2", 32'(count[0]), 32'd1);
        check("burst_txd_start", 32'(txd[0]), 32'd0);
        wr_data = seq[2]; tick();
        check("burst_count_e3", 32'(count[0]), 32'd2);
        wr_data = seq[3]; tick();
        check("burst_count_e4", 32'(count[0]), 32'd3);
        check("burst_not_full_e4", 32'(full[0]), 32'd0);
        wr_data = seq[4]; tick();
        check("burst_count_e5", 32'(count[0]), 32'd4);
        check("burst_full_e5", 32'(full[0]), 32'd1);
        wr_data = 8'hEE; tick();
        wr_en[0] = 1'b0;
        check("ovf_pulse", 32'(overflow[0]), 32'd1);
        check("ovf_count_held", 32'(count[0]), 32'd4);
        tick();
        check("ovf_one_cycle", 32'(overflow[0]), 32'd0);
        cap = '0;
        for (int c = 5; c < 600; c++) begin
            if (c % 12 == 6) cap[c / 12] = txd[0];
            if (c == 599) check("burst_busy_last_cycle", 32'(busy[0]), 32'd1);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("burst_frame%0d", k), 32'(cap[10 * k +: 10]), 32'({1'b1, seq[k], 1'b0}));
        end
        check("burst_busy_done", 32'(busy[0]), 32'd0);
        check("burst_count_done", 32'(count[0]), 32'd0);
        check("burst_empty_done", 32'(empty[0]), 32'd1);
        tick();

        // Write at full on the same edge the FSM pops at end of stop
        wr_en[0] = 1'b1;
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_data = 8'h44; tick();
        wr_data = 8'h55; tick();
        wr_en[0] = 1'b0;
        for (int c = 3; c < 119; c++) tick();
        check("race_count_pre", 32'(count[0]), 32'd4);
        check("race_full_pre", 32'(full[0]), 32'd1);
        wr_data = 8'hA5;
        wr_en[0] = 1'b1;
        tick();
        wr_en[0] = 1'b0;
        check("race_overflow", 32'(overflow[0]), 32'd1);
        check("race_count", 32'(count[0]), 32'd3);
        check("race_busy", 32'(busy[0]), 32'd1);
        for (int c = 0; c < 700 && busy[0]; c++) tick();
        check("race_drained_busy", 32'(busy[0]), 32'd0);
        check("race_drained_count", 32'(count[0]), 32'd0);
        tick();

        // Reset in the third data bit with two bytes queued
        wr_en[0] = 1'b1;
        wr_data = 8'hF0; tick();
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_en[0] = 1'b0;
        check("mid_count_queued", 32'(count[0]), 32'd2);
        for (int c = 1; c < 42; c++) tick();
        check("mid_txd_bit2", 32'(txd[0]), 32'd0);
        #3;
        resetn = 1'b0;
        #1;
        check("mid_rst_txd", 32'(txd[0]), 32'd1);
        check("mid_rst_count", 32'(count[0]), 32'd0);
        check("mid_rst_busy", 32'(busy[0]), 32'd0);
        check("mid_rst_empty", 32'(empty[0]), 32'd1);
        tick();
        tick();
        resetn = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            seen = seen | busy[0] | ~txd[0];
        end
        check("post_rst_quiet", 32'(seen), 32'd0);
        check("post_rst_count", 32'(count[0]), 32'd0);
        send_capture(0, 8'h5A, 16'h02B4, 120, "post_rst_f5a");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated write FIFO, the successor to the fixed 8N1 serial transmit path behind the board-level `serial_txd` pin. Baud rate, data width, parity mode, stop-bit count and FIFO depth are all generics. The block accepts bytes from the core (6502 bus bridge or status reporter) at full clock rate, buffers them, and serialises back-to-back frames with no idle gap. It sits between the core logic and the top-level `serial_txd` pad in the 12 MHz domain.

## Interface
- `CLK_HZ`, 12000000: input clock frequency.
- `BAUD`, 115200: line rate. Divider DIV = (CLK_HZ + BAUD/2) / BAUD, integer; elaboration must fail if DIV < 2.
- `DATA_BITS`, 8: payload bits per frame, 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries, power of two, ≥ 2.

Ports:
- `clk` in 1: single clock. Everything is synchronous to its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `wr_data` in DATA_BITS: byte to enqueue.
- `wr_en` in 1: enqueue strobe, sampled every cycle.
- `full` out 1: FIFO holds FIFO_DEPTH entries.
- `empty` out 1: FIFO holds 0 entries.
- `count` out $clog2(FIFO_DEPTH+1): current occupancy.
- `overflow` out 1: one-cycle pulse when `wr_en` is asserted while `full`.
- `busy` out 1: a frame is on the line (state ≠ IDLE).
- `txd` out 1: serial output. Idle high, registered.

## Operation
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - `full` and `empty` are derived from the registered `count`.
  - Write when `wr_en && !full`. A write with `full` is dropped and pulses `overflow`.
  - `full` is evaluated on the pre-edge state: a write at full is dropped even if a pop happens in the same cycle.
  - A simultaneous push and pop leaves `count` unchanged.
- Frame, LSB first: start (0), DATA_BITS data, optional parity, STOP_BITS stop (1).
  - Odd parity: XOR of data bits inverted.
  - Even parity: XOR of data bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if `!empty`, pop the head into the shift register, `txd`←0, baud counter←0, go to START. Otherwise `txd`←1.
  - START: after DIV cycles go to DATA with bit index 0 and drive data bit 0.
  - DATA: every DIV cycles shift out the next bit. After bit DATA_BITS-1 go to PARITY if PARITY≠0, else STOP.
  - PARITY: hold for DIV cycles, then go to STOP.
  - STOP: hold `txd`=1 for STOP_BITS×DIV cycles.
    - At the end of STOP, if `!empty`, pop and go directly to START (no idle cycle).
    - Otherwise go to IDLE.
- The baud counter counts 0..DIV-1 and is restarted at each frame start. There is no fractional accumulation.
- Writes during transmission never disturb the frame in flight.

## Timing
- Reset values: `txd`=1, `busy`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, state IDLE, pointers 0.
- Reset asserted mid-frame: `txd` goes to 1 asynchronously and all FIFO contents are discarded.
- Latency: a write at edge N into an empty FIFO with the FSM idle gives `count`=1 after edge N. `txd` falls after edge N+1, and `busy` rises on that same edge.
  - That pop returns `count` to 0 after edge N+1.
- Each bit lasts exactly DIV cycles.
- Frame length is DIV×(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `overflow` is registered and asserts the cycle after the offending `wr_en`.

## Test plan
Unless stated otherwise, the bench uses CLK_HZ=12000000, BAUD=1000000 (DIV=12), DATA_BITS=8, FIFO_DEPTH=4.
- Reset → `txd`=1, `empty`=1, `count`=0, `busy`=0.
- Write 0x55, PARITY=0, STOP_BITS=1:
  - `txd` falls exactly 1 cycle after the write edge.
  - Bit samples taken at mid-bit read 0,1,0,1,0,1,0,1,0,1.
  - The frame lasts 120 cycles, after which `busy`=0.
- Write 0x07 with PARITY=2, then again with PARITY=1:
  - PARITY=2 → parity bit 1.
  - PARITY=1 → parity bit 0.
  - Frame length is 132 cycles with STOP_BITS=1, and 144 cycles with STOP_BITS=2.
- Write 5 bytes on consecutive cycles while the FSM is idle:
  - The first byte is popped as `count` reaches 1, so all 5 are accepted. Verify `full` asserts when 4 entries are held.
  - One further write at full → `overflow` pulses for 1 cycle, `count` stays 4, and the byte never appears on `txd`.
  - All accepted bytes transmit in order with no idle gap between frames.
- Write 0xA5 at a full FIFO on the same edge the FSM pops an entry → the write is dropped, `overflow`=1, and `count` ends at 3.
- Assert `resetn`=0 during the 3rd data bit, with 2 bytes queued:
  - `txd`=1 immediately and `count`=0.
  - After release, no further frames are sent until a new write.
